// File: rtl/soc_periph_evt_tx_if.sv
// Peripheral-event stream toward the cluster event unit: one event ID per valid/ready handshake.
interface soc_periph_evt_tx_if #(
  parameter int EVNT_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [EVNT_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/soc_periph_evt_tx.sv
// Collects SoC peripheral event pulses into pending bits, round-robin arbitrates them into an
// event-ID FIFO and drains it over the cluster handshake, counting events lost to collisions.
module soc_periph_evt_tx #(
  parameter int NB_SRC      = 16,
  parameter int EVNT_WIDTH  = 8,
  parameter int EVT_ID_BASE = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_SRC-1:0]   evt_src_i,
  soc_periph_evt_tx_if.master evt_if,
  output logic                lost_evt_o,
  output logic [15:0]         lost_cnt_o,
  input  logic                lost_clr_i,
  output logic                busy_o
);

  localparam int SRC_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int DROP_W = $clog2(NB_SRC + 1);
  localparam logic [EVNT_WIDTH-1:0] ID_BASE  = EVNT_WIDTH'(EVT_ID_BASE);
  localparam logic [SRC_W-1:0]      LAST_SRC = SRC_W'(NB_SRC - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);

  if (EVT_ID_BASE + NB_SRC > 2 ** EVNT_WIDTH) begin : g_bad_id_range
    $error("soc_periph_evt_tx: EVT_ID_BASE+NB_SRC exceeds the event ID space");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("soc_periph_evt_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [NB_SRC-1:0]     pend_reg, pend_next, gnt_onehot, drop;
  logic [SRC_W-1:0]      rr_ptr_reg, rr_ptr_next, gnt_idx;
  logic                  gnt_vld;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [EVNT_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [EVNT_WIDTH-1:0] push_data;
  logic                  push, pop, fifo_full;
  logic [DROP_W-1:0]     drop_cnt;
  logic [16:0]           lost_sum;
  logic [15:0]           lost_cnt_reg, lost_cnt_next;
  logic                  lost_evt_reg;

  assign fifo_full = (count_reg == FULL_CNT);
  assign pop       = evt_if.valid & evt_if.ready;

  // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [SRC_W:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NB_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (SRC_W + 1)'(k);
      if (cand >= (SRC_W + 1)'(NB_SRC)) begin
        cand = cand - (SRC_W + 1)'(NB_SRC);
      end
      if (pend_reg[cand[SRC_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SRC_W-1:0];
      end
    end
    if (fifo_full && !pop) begin
      gnt_vld = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NB_SRC; gi++) begin : g_src
    assign gnt_onehot[gi] = gnt_vld && (gnt_idx == SRC_W'(gi));
    assign drop[gi]       = evt_src_i[gi] & pend_reg[gi] & ~gnt_onehot[gi];
    assign pend_next[gi]  = evt_src_i[gi] | (pend_reg[gi] & ~gnt_onehot[gi]);
  end

  always_comb begin
    drop_cnt = '0;
    for (int k = 0; k < NB_SRC; k++) begin
      drop_cnt = drop_cnt + DROP_W'(drop[k]);
    end
  end

  // A clear coinciding with drops restarts the count from this cycle's drops.
  always_comb begin
    lost_sum      = {1'b0, (lost_clr_i ? 16'h0000 : lost_cnt_reg)} + 17'(drop_cnt);
    lost_cnt_next = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (gnt_vld) begin
      rr_ptr_next = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign push      = gnt_vld;
  assign push_data = ID_BASE + EVNT_WIDTH'(gnt_idx);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_reg     <= '0;
      rr_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      lost_cnt_reg <= '0;
      lost_evt_reg <= 1'b0;
    end else begin
      pend_reg     <= pend_next;
      rr_ptr_reg   <= rr_ptr_next;
      wr_ptr_reg   <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg   <= rd_ptr_reg + PTR_W'(pop);
      count_reg    <= count_next;
      lost_cnt_reg <= lost_cnt_next;
      lost_evt_reg <= |drop;
    end
  end

  // Entries are reset so the head reads as 0 straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  assign evt_if.valid = (count_reg != '0);
  assign evt_if.data  = mem_reg[rd_ptr_reg];
  assign lost_evt_o   = lost_evt_reg;
  assign lost_cnt_o   = lost_cnt_reg;
  assign busy_o       = (|pend_reg) | (count_reg != '0);

endmodule

// File: tb/tb_soc_periph_evt_tx.sv
// Directed bench for soc_periph_evt_tx with EVT_ID_BASE=8, 16 sources, 4-entry FIFO.
module tb_soc_periph_evt_tx;
  localparam int W    = 8;
  localparam int BASE = 8;

  logic        clk_i      = 1'b0;
  logic        rst_ni     = 1'b0;
  logic [15:0] evt_src_i  = '0;
  logic        lost_clr_i = 1'b0;
  logic        lost_evt_o;
  logic [15:0] lost_cnt_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;
  logic [7:0] got[$];

  soc_periph_evt_tx_if #(.EVNT_WIDTH(W)) bus ();

  soc_periph_evt_tx #(
    .NB_SRC(16), .EVNT_WIDTH(W), .EVT_ID_BASE(BASE), .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .evt_src_i  (evt_src_i),
    .evt_if     (bus),
    .lost_evt_o (lost_evt_o),
    .lost_cnt_o (lost_cnt_o),
    .lost_clr_i (lost_clr_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int c = 0;
    while (busy_o && c < max_cycles) begin
      tick();
      c++;
    end
    check("idle_reached", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic capture(input int n);
    got.delete();
    for (int c = 0; c < 16 && got.size() < n; c++) begin
      if (bus.valid && bus.ready) got.push_back(bus.data);
      tick();
    end
    check("capture_count", got.size(), n);
  endtask

  initial begin
    bus.ready = 1'b0;
    #2;
    check("rst_valid",    bus.valid,  0);
    check("rst_data",     bus.data,   0);
    check("rst_lost_evt", lost_evt_o, 0);
    check("rst_lost_cnt", lost_cnt_o, 0);
    check("rst_busy",     busy_o,     0);
    tick();
    rst_ni = 1'b1;
    tick();

    // single event on source 3, ID 11 two cycles later
    evt_src_i = 16'h0008;
    bus.ready = 1'b1;
    tick();
    evt_src_i = '0;
    check("single_n1_valid", bus.valid, 0);
    check("single_n1_busy",  busy_o,    1);
    tick();
    check("single_n2_valid", bus.valid, 1);
    check("single_n2_data",  bus.data,  11);
    tick();
    check("single_n3_valid", bus.valid, 0);
    check("single_n3_busy",  busy_o,    0);

    // backpressure: sources 0..5 one per cycle, FIFO fills with 8..11
    bus.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      evt_src_i = 16'(1 << i);
      tick();
    end
    evt_src_i = '0;
    for (int s = 0; s < 3; s++) begin
      check("bp_stall_valid", bus.valid, 1);
      check("bp_stall_data",  bus.data,  8);
      tick();
    end
    check("bp_lost_cnt", lost_cnt_o, 0);
    check("bp_lost_evt", lost_evt_o, 0);
    check("bp_busy",     busy_o,     1);
    bus.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("bp_pop_valid", bus.valid, 1);
      check("bp_pop_data",  bus.data,  32'(8 + k));
      tick();
    end
    check("bp_drained_valid", bus.valid, 0);
    check("bp_drained_busy",  busy_o,    0);

    // park rr_ptr at 2 by granting source 1 alone
    evt_src_i = 16'h0002;
    tick();
    evt_src_i = '0;
    wait_idle(10);

    // round robin from rr_ptr=2 over sources 1,2,7 -> IDs 10,15,9
    evt_src_i = 16'h0086;
    tick();
    evt_src_i = '0;
    capture(3);
    if (got.size() == 3) begin
      check("rr_first",  got[0], 10);
      check("rr_second", got[1], 15);
      check("rr_third",  got[2], 9);
    end
    wait_idle(10);
    // rr_ptr back at 2: source 2 must beat source 1
    evt_src_i = 16'h0006;
    tick();
    evt_src_i = '0;
    capture(2);
    if (got.size() == 2) begin
      check("rr_ptr_first",  got[0], 10);
      check("rr_ptr_second", got[1], 9);
    end
    wait_idle(10);

    // loss: fill FIFO with sources 8..11, then hit source 0 three times
    bus.ready = 1'b0;
    evt_src_i = 16'h0F00;
    tick();
    evt_src_i = '0;
    repeat (4) tick();
    check("loss_full_valid", bus.valid, 1);
    check("loss_full_data",  bus.data,  16);
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      evt_src_i = 16'h0001;
      tick();
      pulses += int'(lost_evt_o);
    end
    evt_src_i = '0;
    tick();
    pulses += int'(lost_evt_o);
    check("loss_pulses",   pulses,     2);
    check("loss_cnt",      lost_cnt_o, 2);
    check("loss_evt_idle", lost_evt_o, 0);
    lost_clr_i = 1'b1;
    evt_src_i  = 16'h0001;
    tick();
    lost_clr_i = 1'b0;
    evt_src_i  = '0;
    check("loss_clr_cnt", lost_cnt_o, 1);
    check("loss_clr_evt", lost_evt_o, 1);

    // saturation: clear with one drop, then 4095*16 + 13 drops -> 65534, then +3
    lost_clr_i = 1'b1;
    evt_src_i  = 16'hFFFF;
    tick();
    lost_clr_i = 1'b0;
    check("sat_start_cnt", lost_cnt_o, 1);
    repeat (4095) tick();
    evt_src_i = 16'h1FFF;
    tick();
    check("sat_preload", lost_cnt_o, 16'hFFFE);
    evt_src_i = 16'h0007;
    tick();
    check("sat_cnt", lost_cnt_o, 16'hFFFF);
    check("sat_evt", lost_evt_o, 1);
    evt_src_i = 16'h0001;
    tick();
    evt_src_i = '0;
    check("sat_hold", lost_cnt_o, 16'hFFFF);

    // reset mid-operation with three IDs queued and a handshake in progress
    bus.ready = 1'b1;
    wait_idle(40);
    check("pre_rst_cnt", lost_cnt_o, 16'hFFFF);
    bus.ready = 1'b0;
    evt_src_i = 16'h0070;
    tick();
    evt_src_i = '0;
    repeat (3) tick();
    check("pre_rst_valid", bus.valid, 1);
    check("pre_rst_data",  bus.data,  12);
    bus.ready = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid",    bus.valid,  0);
    check("mid_rst_busy",     busy_o,     0);
    check("mid_rst_lost_cnt", lost_cnt_o, 0);
    check("mid_rst_data",     bus.data,   0);
    tick();
    rst_ni    = 1'b1;
    evt_src_i = 16'h0200;
    tick();
    evt_src_i = '0;
    check("post_rst_n1_valid", bus.valid, 0);
    tick();
    check("post_rst_n2_valid", bus.valid, 1);
    check("post_rst_n2_data",  bus.data,  17);
    tick();
    check("post_rst_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
